// File: rtl/mmio_router.sv
// Host-bus to N-channel MMIO router: window/range decode, RD_LAT tag pipeline, in-order response FIFO.
// Optional feature macro MMIO_ROUTER_ERR_EN enables bus_err and the saturating err_cnt on decode misses.
module mmio_router #(
   parameter int                        ADDR_W     = 64,
   parameter int                        DATA_W     = 64,
   parameter int                        LADDR_W    = 16,
   parameter int                        N_CH       = 3,
   parameter logic [ADDR_W-1:0]         WIN_BASE   = 64'h4000_0000,
   parameter logic [ADDR_W-1:0]         WIN_END    = 64'h8000_0000,
   parameter logic [N_CH*LADDR_W-1:0]   CH_BASE    = {16'h2E00, 16'h2A00, 16'h0000},
   parameter logic [N_CH*LADDR_W-1:0]   CH_END     = {16'h2E01, 16'h2DFF, 16'h29FF},
   parameter int                        RD_LAT     = 1,
   parameter int                        RESP_DEPTH = 4,
   parameter logic [DATA_W-1:0]         MISS_RDATA = 64'hCA11AB1EBADCAB1E
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bus_req,
   output logic                         bus_gnt,
   input  logic                         bus_we,
   input  logic [ADDR_W-1:0]            bus_addr,
   input  logic [DATA_W-1:0]            bus_wdata,
   input  logic [DATA_W/8-1:0]          bus_be,
   output logic                         bus_rvalid,
   input  logic                         bus_rready,
   output logic [DATA_W-1:0]            bus_rdata,
   output logic                         bus_err,
   output logic [N_CH-1:0]              ch_en,
   output logic [N_CH-1:0]              ch_we,
   output logic [N_CH*LADDR_W-1:0]      ch_addr,
   output logic [N_CH*DATA_W-1:0]       ch_wdata,
   output logic [N_CH*DATA_W/8-1:0]     ch_be,
   input  logic [N_CH*DATA_W-1:0]       ch_rdata,
   input  logic [N_CH-1:0]              ch_stall,
   output logic [15:0]                  err_cnt
);

   localparam int BE_W = DATA_W / 8;
   localparam int OFF  = $clog2(BE_W);
   localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PW   = $clog2(RESP_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(RESP_DEPTH);

   typedef struct packed {
      logic          we;
      logic          miss;
      logic [CW-1:0] ch;
   } tag_t;

   logic               in_win, hit, acc, pop, push;
   logic [LADDR_W-1:0] waddr;
   logic [CW-1:0]      hit_ch;

   assign in_win = (bus_addr >= WIN_BASE) && (bus_addr < WIN_END);
   assign waddr  = bus_addr[LADDR_W+OFF-1:OFF];

   // Scan high to low so the lowest matching index is the one left standing.
   always_comb begin
      hit    = 1'b0;
      hit_ch = '0;
      for (int i = N_CH-1; i >= 0; i--) begin
         if (in_win && waddr >= CH_BASE[i*LADDR_W +: LADDR_W]
                    && waddr <= CH_END[i*LADDR_W +: LADDR_W]) begin
            hit    = 1'b1;
            hit_ch = CW'(i);
         end
      end
   end

   logic [PW-1:0]     wptr_q, rptr_q;
   logic [PW:0]       fcnt_q, outst_q;
   logic [DATA_W-1:0] fdata_q [RESP_DEPTH];
   logic [RESP_DEPTH-1:0] ferr_q;

   assign bus_rvalid = (fcnt_q != '0);
   assign pop        = bus_rvalid & bus_rready;
   // A pop in the same cycle frees a slot, which keeps streaming bubble-free when full.
   assign bus_gnt    = rst & bus_req & ((outst_q < DEPTH_C) | pop) & ~(hit & ch_stall[hit_ch]);
   assign acc        = bus_req & bus_gnt;

   always_comb begin
      ch_en    = '0;
      ch_we    = '0;
      ch_addr  = '0;
      ch_wdata = '0;
      ch_be    = '0;
      if (acc && hit) begin
         ch_en[hit_ch] = 1'b1;
         ch_we[hit_ch] = bus_we;
         ch_addr[hit_ch*LADDR_W +: LADDR_W] = waddr - CH_BASE[hit_ch*LADDR_W +: LADDR_W];
         if (bus_we) begin
            ch_wdata[hit_ch*DATA_W +: DATA_W] = bus_wdata;
            ch_be[hit_ch*BE_W +: BE_W]        = bus_be;
         end
      end
   end

   // Tag pipeline: stage s holds the transaction accepted s cycles ago.
   tag_t              tag_pipe_q [1:RD_LAT];
   logic [RD_LAT:1]   vld_pipe_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe_q <= '0;
         for (int s = 1; s <= RD_LAT; s++) tag_pipe_q[s] <= '0;
      end else begin
         vld_pipe_q[1] <= acc;
         tag_pipe_q[1] <= '{we: bus_we, miss: ~hit, ch: hit_ch};
         for (int s = 2; s <= RD_LAT; s++) begin
            vld_pipe_q[s] <= vld_pipe_q[s-1];
            tag_pipe_q[s] <= tag_pipe_q[s-1];
         end
      end
   end

   tag_t              ex;
   logic [DATA_W-1:0] resp_data;
   logic              resp_err;

   assign ex   = tag_pipe_q[RD_LAT];
   assign push = vld_pipe_q[RD_LAT];

   always_comb begin
      resp_data = '0;
      resp_err  = 1'b0;
      if (ex.miss) begin
         if (!ex.we) resp_data = MISS_RDATA;
`ifdef MMIO_ROUTER_ERR_EN
         resp_err = 1'b1;
`endif
      end else if (!ex.we) begin
         resp_data = ch_rdata[ex.ch*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fdata_q[wptr_q] <= resp_data;
         ferr_q[wptr_q]  <= resp_err;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         fcnt_q  <= '0;
         outst_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         if (push && !pop)      fcnt_q <= fcnt_q + 1'b1;
         else if (!push && pop) fcnt_q <= fcnt_q - 1'b1;
         if (acc && !pop)       outst_q <= outst_q + 1'b1;
         else if (!acc && pop)  outst_q <= outst_q - 1'b1;
      end
   end

   assign bus_rdata = bus_rvalid ? fdata_q[rptr_q] : '0;
   assign bus_err   = bus_rvalid & ferr_q[rptr_q];

`ifdef MMIO_ROUTER_ERR_EN
   logic [15:0] err_cnt_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                             err_cnt_q <= '0;
      else if (pop && ferr_q[rptr_q] && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
   end
   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule
